if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched {PC, instruction} pairs so that fetch keeps running while decode stalls, and it discards all buffered entries when a taken branch redirects the PC. It consumes the PCOut/instruction pair produced by fetch and presents the oldest entry to decode through a valid/ready handshake.

## Interface
- DEPTH, 4, number of entries; legal values are 2, 4, 8 and 16.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- PCIn  input  32  PC of the fetched instruction, taken from fetch PCOut
- instructionIn  input  32  fetched instruction word
- fetchValid  input  1  PCIn/instructionIn are valid this cycle
- fetchReady  output  1  queue accepts a push this cycle
- flush  input  1  taken branch (fetch PCSrc); discards all entries
- PCOut  output  32  PC of the head entry
- instructionOut  output  32  instruction of the head entry; 32'h00000000 when validOut=0
- validOut  output  1  head entry present
- decodeReady  input  1  decode consumes the head this cycle
- count  output  clog2(DEPTH)+1  number of stored entries

## Operation
- Storage is a circular buffer with write pointer wp, read pointer rp and occupancy count. Pointers wrap modulo DEPTH.
- push = fetchValid & fetchReady. A push writes {PCIn, instructionIn} at wp, then wp advances by 1.
- pop = validOut & decodeReady. A pop advances rp by 1.
- fetchReady = (count < DEPTH), driven combinationally from registered count only. When full, no push occurs even if a pop happens in the same cycle.
- count_next = count + push − pop. A push and pop in the same cycle leave count unchanged. Pops and pushes are never ignored while the queue is non-full and non-empty.
- validOut = (count != 0). PCOut and instructionOut come from entry rp.
- When validOut=0: PCOut = 32'h00000000 and instructionOut = 32'h00000000 (a bubble).
- flush has priority over push and pop.
  - On flush, wp, rp and count go to 0 at the next edge.
  - A push presented in the flush cycle is discarded.
  - The head shown during the flush cycle counts as not consumed.
- Storage contents are not cleared by reset or flush. Only the pointers and count are cleared.
- The ordering is strict FIFO. PC/instruction pairs never separate.

## Timing
- Reset (asynchronous): wp=0, rp=0, count=0. As a result validOut=0, fetchReady=1, and PCOut/instructionOut = 0.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency without bypass: an entry pushed at edge N is at the output, with validOut=1, after edge N. Decode can consume it in cycle N+1.
- Throughput is one push and one pop per cycle.
- flush asserted in cycle N: validOut=0 and count=0 after edge N. A push in cycle N+1 is accepted normally.
- fetchReady depends only on state, not on decodeReady. This means there is no combinational path from decode to fetch.

## Configuration
- IF_ID_BYPASS_EN defined: when count=0 and fetchValid=1 and flush=0, the outputs show the input in the same cycle.
  - validOut=1, PCOut=PCIn, instructionOut=instructionIn.
  - If decodeReady=1 in that cycle, the entry is consumed and never written: pointers and count are unchanged.
  - If decodeReady=0, the entry is written normally.
  - This adds combinational paths from fetchValid, PCIn and instructionIn to the outputs.
- IF_ID_BYPASS_EN undefined: the outputs depend only on registered state, and the minimum latency is 1 cycle as described above.

## Test plan
- Reset mid-stream: with 3 entries held, assert rst asynchronously between edges → count=0, validOut=0, fetchReady=1, and instructionOut=0 before the next edge.
- Fill and stall: DEPTH=4, decodeReady=0, push PCs 0x0, 0x4, 0x8, 0xC, 0x10 → the first four are accepted, count=4, fetchReady=0, and 0x10 is held off. Then raise decodeReady → PCOut sequence 0x0, 0x4, 0x8, 0xC, and 0x10 is accepted after the first pop.
- Streaming: fetchValid=1 and decodeReady=1 continuously, PCs 0x100 upward in steps of 4 for 20 cycles → count stays at 1, or 0 with the bypass, and every PC appears exactly once in order. Pointer wrap is exercised 5 times.
- Flush with push: count=2, with flush=1 and fetchValid=1 (PC 0x40) in the same cycle → next cycle count=0 and validOut=0. A push of PC 0x80 in the following cycle reaches the head and 0x40 never appears.
- Simultaneous push/pop at count=3 → count stays 3, the head advances, and the new entry becomes the tail.
- Bypass (compiled with IF_ID_BYPASS_EN): queue empty, push PC 0x200 with decodeReady=1 → PCOut=0x200 and validOut=1 in the same cycle, and count remains 0 after the edge. Without the macro → validOut=0 that cycle and PCOut=0x200 in the next cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {PC, instruction} pairs.
// Define IF_ID_BYPASS_EN to let an empty queue forward fetch data to decode in the same cycle.
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              PCIn,
    input  logic [31:0]              instructionIn,
    input  logic                     fetchValid,
    output logic                     fetchReady,
    input  logic                     flush,
    output logic [31:0]              PCOut,
    output logic [31:0]              instructionOut,
    output logic                     validOut,
    input  logic                     decodeReady,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    logic empty;
    logic push;
    logic pop;
    logic wr;
    logic rd;
    logic byp;

    assign empty      = (count == '0);
    assign fetchReady = (count < CW'(DEPTH));
    assign push       = fetchValid & fetchReady;

`ifdef IF_ID_BYPASS_EN
    assign byp = empty & fetchValid & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign validOut = ~empty | byp;
    assign pop      = validOut & decodeReady;

    // A bypassed entry taken by decode is never stored.
    assign wr = push & ~flush & ~(byp & decodeReady);
    assign rd = pop & ~byp & ~flush;

    always_comb begin
        PCOut          = '0;
        instructionOut = '0;
        if (byp) begin
            PCOut          = PCIn;
            instructionOut = instructionIn;
        end else if (!empty) begin
            PCOut          = pc_mem[rp];
            instructionOut = ins_mem[rp];
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wp]  <= PCIn;
            ins_mem[wp] <= instructionIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + PW'(1);
            if (rd) rp <= rp + PW'(1);
            unique case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
// Expectations follow IF_ID_BYPASS_EN when the bench is built with it.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCIn;
    logic [31:0] instructionIn;
    logic        fetchValid;
    logic        fetchReady;
    logic        flush;
    logic [31:0] PCOut;
    logic [31:0] instructionOut;
    logic        validOut;
    logic        decodeReady;
    logic [2:0]  count;

    int cmps = 0;
    int errs = 0;

    if_id_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .PCIn(PCIn), .instructionIn(instructionIn),
        .fetchValid(fetchValid), .fetchReady(fetchReady),
        .flush(flush),
        .PCOut(PCOut), .instructionOut(instructionOut),
        .validOut(validOut), .decodeReady(decodeReady),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic fv, input logic [31:0] pc,
                         input logic dr, input logic fl);
        fetchValid    = fv;
        PCIn          = pc;
        instructionIn = ~pc;
        decodeReady   = dr;
        flush         = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cmps++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", validOut); end
        cmps++; if (fetchReady !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", fetchReady); end
        cmps++; if (PCOut !== 32'h0) begin errs++; $display("FAIL reset_pc got %h exp 0", PCOut); end
        cmps++; if (instructionOut !== 32'h0) begin errs++; $display("FAIL reset_ins got %h exp 0", instructionOut); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, exp_pc[i], 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        cmps++; if (count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d exp 4", count); end
        cmps++; if (fetchReady !== 1'b0) begin errs++; $display("FAIL fill_ready got %b exp 0", fetchReady); end
        step();
        cmps++; if (count !== 3'd4) begin errs++; $display("FAIL fill_held got %0d exp 4", count); end
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        cmps++; if (fetchReady !== 1'b0) begin errs++; $display("FAIL full_pop_ready got %b exp 0", fetchReady); end
        for (int i = 0; i < 5; i++) begin
            cmps++; if (PCOut !== exp_pc[i]) begin errs++; $display("FAIL drain_pc%0d got %h exp %h", i, PCOut, exp_pc[i]); end
            cmps++; if (instructionOut !== ~exp_pc[i]) begin errs++; $display("FAIL drain_ins%0d got %h exp %h", i, instructionOut, ~exp_pc[i]); end
            step();
            if (i == 0) begin
                cmps++; if (count !== 3'd3) begin errs++; $display("FAIL after_pop_count got %0d exp 3", count); end
            end
            if (i == 1) begin
                cmps++; if (count !== 3'd3) begin errs++; $display("FAIL refill_count got %0d exp 3", count); end
            end
            if (i >= 1) drive(1'b0, 32'h0, 1'b1, 1'b0);
        end
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL drain_empty got %b exp 0", validOut); end
        cmps++; if (instructionOut !== 32'h0) begin errs++; $display("FAIL bubble_ins got %h exp 0", instructionOut); end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        for (int k = 0; k < 20; k++) begin
            pc = 32'h100 + 32'(4 * k);
            drive(1'b1, pc, 1'b1, 1'b0);
`ifdef IF_ID_BYPASS_EN
            cmps++; if (PCOut !== pc) begin errs++; $display("FAIL stream_pc%0d got %h exp %h", k, PCOut, pc); end
            cmps++; if (count !== 3'd0) begin errs++; $display("FAIL stream_count%0d got %0d exp 0", k, count); end
`else
            if (k == 0) begin
                cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL stream_first_valid got %b exp 0", validOut); end
            end else begin
                cmps++; if (PCOut !== pc - 32'h4) begin errs++; $display("FAIL stream_pc%0d got %h exp %h", k, PCOut, pc - 32'h4); end
                cmps++; if (count !== 3'd1) begin errs++; $display("FAIL stream_count%0d got %0d exp 1", k, count); end
            end
`endif
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifndef IF_ID_BYPASS_EN
        cmps++; if (PCOut !== 32'h14C) begin errs++; $display("FAIL stream_last got %h exp 14c", PCOut); end
        step();
`endif
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL stream_end_valid got %b exp 0", validOut); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20, 1'b0, 1'b0); step();
        drive(1'b1, 32'h24, 1'b0, 1'b0); step();
        cmps++; if (count !== 3'd2) begin errs++; $display("FAIL flush_pre got %0d exp 2", count); end
        drive(1'b1, 32'h40, 1'b0, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cmps++; if (count !== 3'd0) begin errs++; $display("FAIL flush_count got %0d exp 0", count); end
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL flush_valid got %b exp 0", validOut); end
        drive(1'b1, 32'h80, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cmps++; if (count !== 3'd1) begin errs++; $display("FAIL flush_push_count got %0d exp 1", count); end
        cmps++; if (PCOut !== 32'h80) begin errs++; $display("FAIL flush_head got %h exp 80", PCOut); end
        step();
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL flush_no40 got %b exp 0", validOut); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h30C, 1'b1, 1'b0);
        cmps++; if (PCOut !== 32'h300) begin errs++; $display("FAIL simul_head0 got %h exp 300", PCOut); end
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cmps++; if (count !== 3'd3) begin errs++; $display("FAIL simul_count got %0d exp 3", count); end
        for (int i = 0; i < 3; i++) begin
            cmps++; if (PCOut !== 32'h304 + 32'(4 * i)) begin errs++; $display("FAIL simul_order%0d got %h exp %h", i, PCOut, 32'h304 + 32'(4 * i)); end
            step();
        end
        cmps++; if (count !== 3'd0) begin errs++; $display("FAIL simul_end got %0d exp 0", count); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h200, 1'b1, 1'b0);
`ifdef IF_ID_BYPASS_EN
        cmps++; if (validOut !== 1'b1) begin errs++; $display("FAIL byp_valid got %b exp 1", validOut); end
        cmps++; if (PCOut !== 32'h200) begin errs++; $display("FAIL byp_pc got %h exp 200", PCOut); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cmps++; if (count !== 3'd0) begin errs++; $display("FAIL byp_count got %0d exp 0", count); end
`else
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL byp_valid got %b exp 0", validOut); end
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cmps++; if (PCOut !== 32'h200) begin errs++; $display("FAIL byp_pc got %h exp 200", PCOut); end
        cmps++; if (count !== 3'd1) begin errs++; $display("FAIL byp_count got %0d exp 1", count); end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cmps++; if (count !== 3'd0) begin errs++; $display("FAIL byp_drain got %0d exp 0", count); end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cmps++; if (count !== 3'd3) begin errs++; $display("FAIL mid_pre got %0d exp 3", count); end
        #1 rst = 1'b1;
        #1;
        cmps++; if (count !== 3'd0) begin errs++; $display("FAIL mid_count got %0d exp 0", count); end
        cmps++; if (validOut !== 1'b0) begin errs++; $display("FAIL mid_valid got %b exp 0", validOut); end
        cmps++; if (fetchReady !== 1'b1) begin errs++; $display("FAIL mid_ready got %b exp 1", fetchReady); end
        cmps++; if (instructionOut !== 32'h0) begin errs++; $display("FAIL mid_ins got %h exp 0", instructionOut); end
        #1 rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_stream();
        test_flush();
        test_simul();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
